// File: rtl/bcd_mod_counter_pkg.sv
// Shared constants and helpers for the BCD modulo counter.
//   BCD_W      : bits per BCD digit
//   BCD_MAX    : largest legal digit value
//   MAX_DIGITS : widest count to_bcd can encode
//   to_bcd()   : integer -> packed BCD, used at elaboration for the
//                terminal value and by the testbench reference model
package bcd_mod_counter_pkg;

    localparam int          BCD_W      = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam int          MAX_DIGITS = 8;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int unsigned                 v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[BCD_W*i +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter_digit.sv
// Single BCD digit of the modulo counter.
//   clk_i, reset_i : clock, async active-high reset
//   clear_i        : synchronous clear to 0 (highest priority)
//   load_i         : synchronous load of load_val_i
//   step_i         : carry/borrow in; step this digit by one
//   up_i           : 1 = increment, 0 = decrement
//   q_o            : digit value
//   cout_o         : carry (9 -> 0) or borrow (0 -> 9) out to the next digit
module bcd_digit
    import bcd_mod_counter_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             step_i,
    input  logic             up_i,
    output logic [BCD_W-1:0] q_o,
    output logic             cout_o
);

    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = load_val_i;
        end else if (step_i) begin
            if (up_i) digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
            else      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    assign cout_o = step_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == '0));
    assign q_o    = digit_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) digit_q <= '0;
        else         digit_q <= digit_d;
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD up/down counter, modulo MODULUS over DIGITS digits.
//   clk_i, reset_i : clock, async active-high reset
//   en_i, up_i     : count enable and direction
//   clear_i        : synchronous clear (beats load and en)
//   load_i         : synchronous load of load_val_i (beats en), validated
//   q_o            : count in BCD, digit 0 in [3:0]
//   co_o           : registered one-cycle wrap pulse
//   load_err_o     : registered one-cycle pulse for a rejected load
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int DIGITS  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [BCD_W*DIGITS-1:0] load_val_i,
    output logic [BCD_W*DIGITS-1:0] q_o,
    output logic                  co_o,
    output logic                  load_err_o
);

    localparam int              W    = BCD_W*DIGITS;
    localparam logic [W-1:0]    TERM = W'(to_bcd(MODULUS-1));

    logic          load_ok;
    logic          step;
    logic          wrap_up, wrap_dn;
    logic          dig_clear, dig_load;
    logic [W-1:0]  dig_load_val;
    logic [DIGITS:0] chain;
    logic          co_q, co_d;
    logic          load_err_q, load_err_d;

    // For well-formed BCD, packed comparison orders the same as the
    // decimal value, so "< MODULUS" becomes "<= TERM".
    always_comb begin
        load_ok = (load_val_i <= TERM);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val_i[BCD_W*i +: BCD_W] > BCD_MAX) load_ok = 1'b0;
        end
    end

    assign step     = en_i & ~clear_i & ~load_i;
    assign chain[0] = step;

    assign wrap_up = step & up_i & (q_o == TERM);
    // A borrow out of the top digit means the count was all zeros.
    assign wrap_dn = chain[DIGITS] & ~up_i;

    // Wraps reuse the digits' clear/load paths, which override stepping.
    assign dig_clear    = clear_i | wrap_up;
    assign dig_load     = (load_i & load_ok) | wrap_dn;
    assign dig_load_val = load_i ? load_val_i : TERM;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .clear_i    (dig_clear),
            .load_i     (dig_load),
            .load_val_i (dig_load_val[BCD_W*g +: BCD_W]),
            .step_i     (chain[g]),
            .up_i       (up_i),
            .q_o        (q_o[BCD_W*g +: BCD_W]),
            .cout_o     (chain[g+1])
        );
    end

    assign co_d       = wrap_up | wrap_dn;
    assign load_err_d = load_i & ~clear_i & ~load_ok;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            co_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            co_q       <= co_d;
            load_err_q <= load_err_d;
        end
    end

    assign co_o       = co_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;
    import bcd_mod_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
    logic [11:0] load_val = '0;

    logic [7:0]  q60, q24;
    logic [11:0] q1k;
    logic        co60, co24, co1k, le60, le24, le1k;

    int errors = 0;
    int checks = 0;

    // reference model state: plain integer counts
    int m60 = 0, m24 = 0, m1k = 0;
    bit c60, c24, c1k, e60, e24, e1k;

    always #5 clk = ~clk;

    bcd_mod_counter #(.MODULUS(60), .DIGITS(2)) dut60 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .clear_i(clear),
        .load_i(load), .load_val_i(load_val[7:0]), .q_o(q60), .co_o(co60), .load_err_o(le60));

    bcd_mod_counter #(.MODULUS(24), .DIGITS(2)) dut24 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .clear_i(clear),
        .load_i(load), .load_val_i(load_val[7:0]), .q_o(q24), .co_o(co24), .load_err_o(le24));

    bcd_mod_counter #(.MODULUS(1000), .DIGITS(3)) dut1k (
        .clk_i(clk), .reset_i(reset), .en_i(en), .up_i(up), .clear_i(clear),
        .load_i(load), .load_val_i(load_val), .q_o(q1k), .co_o(co1k), .load_err_o(le1k));

    function automatic logic [7:0] bcd8(input int v);
        return 8'(to_bcd(v));
    endfunction

    function automatic logic [11:0] bcd12(input int v);
        return 12'(to_bcd(v));
    endfunction

    // One clock edge of the behaviour described by the counter's rules,
    // using decimal integers.
    task automatic model(input int cur, input int md, input int nd,
                         output int nxt, output bit co, output bit er);
        int val = 0;
        int p = 1;
        bit ok = 1'b1;
        for (int i = 0; i < nd; i++) begin
            int d;
            d = int'(load_val[4*i +: 4]);
            if (d > 9) ok = 1'b0;
            val += d * p;
            p *= 10;
        end
        if (val >= md) ok = 1'b0;
        nxt = cur; co = 1'b0; er = 1'b0;
        if (clear) nxt = 0;
        else if (load) begin
            if (ok) nxt = val;
            else    er  = 1'b1;
        end else if (en) begin
            if (up) begin
                if (cur == md-1) begin nxt = 0; co = 1'b1; end
                else nxt = cur + 1;
            end else begin
                if (cur == 0) begin nxt = md-1; co = 1'b1; end
                else nxt = cur - 1;
            end
        end
    endtask

    task automatic drive(input bit e, input bit u, input bit c, input bit l, input logic [11:0] lv);
        int n;
        en = e; up = u; clear = c; load = l; load_val = lv;
        @(posedge clk);
        #1;
        model(m60, 60, 2, n, c60, e60);   m60 = n;
        model(m24, 24, 2, n, c24, e24);   m24 = n;
        model(m1k, 1000, 3, n, c1k, e1k); m1k = n;
        en = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (q60 !== 8'h00 || co60 !== 1'b0 || le60 !== 1'b0) begin
            errors++; $display("FAIL reset60: q=%h co=%b err=%b want 00 0 0", q60, co60, le60);
        end
        checks++;
        if (q1k !== 12'h000 || co1k !== 1'b0 || le1k !== 1'b0) begin
            errors++; $display("FAIL reset1k: q=%h co=%b err=%b want 000 0 0", q1k, co1k, le1k);
        end
        #5 reset = 1'b0;
        m60 = 0; m24 = 0; m1k = 0;
    endtask

    task automatic test_count_up();
        int ncos = 0;
        int first = -1;
        int second = -1;
        for (int i = 1; i <= 120; i++) begin
            drive(1, 1, 0, 0, 12'h000);
            checks++;
            if (q60 !== bcd8(i % 60)) begin
                errors++; $display("FAIL up_q step %0d: got %h want %h", i, q60, bcd8(i % 60));
            end
            checks++;
            if (co60 !== ((i % 60) == 0)) begin
                errors++; $display("FAIL up_co step %0d: got %b want %b", i, co60, (i % 60) == 0);
            end
            if (co60 === 1'b1) begin
                ncos++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
        end
        checks++;
        if (ncos !== 2 || (second - first) !== 60) begin
            errors++; $display("FAIL co_period: pulses=%0d period=%0d want 2 and 60", ncos, second - first);
        end
    endtask

    task automatic test_count_down();
        drive(0, 1, 1, 0, 12'h000);
        drive(1, 0, 0, 0, 12'h000);
        checks++;
        if (q60 !== 8'h59 || co60 !== 1'b1) begin
            errors++; $display("FAIL down_wrap: q=%h co=%b want 59 1", q60, co60);
        end
        drive(1, 0, 0, 0, 12'h000);
        checks++;
        if (q60 !== 8'h58 || co60 !== 1'b0) begin
            errors++; $display("FAIL down_step: q=%h co=%b want 58 0", q60, co60);
        end
        drive(0, 0, 0, 1, 12'h010);
        drive(1, 0, 0, 0, 12'h000);
        checks++;
        if (q60 !== 8'h09 || co60 !== 1'b0) begin
            errors++; $display("FAIL down_borrow: q=%h co=%b want 09 0", q60, co60);
        end
    endtask

    task automatic test_load();
        drive(0, 1, 0, 1, 12'h045);
        checks++;
        if (q60 !== 8'h45 || le60 !== 1'b0) begin
            errors++; $display("FAIL load_ok: q=%h err=%b want 45 0", q60, le60);
        end
        drive(0, 1, 0, 1, 12'h060);
        checks++;
        if (q60 !== 8'h45 || le60 !== 1'b1) begin
            errors++; $display("FAIL load_range: q=%h err=%b want 45 1", q60, le60);
        end
        drive(0, 1, 0, 1, 12'h03A);
        checks++;
        if (q60 !== 8'h45 || le60 !== 1'b1) begin
            errors++; $display("FAIL load_digit: q=%h err=%b want 45 1", q60, le60);
        end
        drive(0, 1, 0, 0, 12'h000);
        checks++;
        if (q60 !== 8'h45 || le60 !== 1'b0 || co60 !== 1'b0) begin
            errors++; $display("FAIL load_idle: q=%h err=%b co=%b want 45 0 0", q60, le60, co60);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 1, 12'h012);
        checks++;
        if (q60 !== 8'h00 || co60 !== 1'b0 || le60 !== 1'b0) begin
            errors++; $display("FAIL clr_over_load: q=%h co=%b err=%b want 00 0 0", q60, co60, le60);
        end
        drive(0, 1, 1, 1, 12'h03A);
        checks++;
        if (q60 !== 8'h00 || le60 !== 1'b0) begin
            errors++; $display("FAIL clr_over_bad_load: q=%h err=%b want 00 0", q60, le60);
        end
        drive(0, 1, 0, 1, 12'h059);
        drive(1, 1, 0, 1, 12'h012);
        checks++;
        if (q60 !== 8'h12 || co60 !== 1'b0) begin
            errors++; $display("FAIL load_over_en: q=%h co=%b want 12 0", q60, co60);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 0, 1, 12'h037);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q60 !== 8'h00 || co60 !== 1'b0) begin
            errors++; $display("FAIL async_rst37: q=%h co=%b want 00 0", q60, co60);
        end
        #1 reset = 1'b0;
        m60 = 0; m24 = 0; m1k = 0;
        drive(0, 1, 0, 1, 12'h059);
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (co60 !== 1'b1) begin
            errors++; $display("FAIL co_before_rst: co=%b want 1", co60);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q60 !== 8'h00 || co60 !== 1'b0) begin
            errors++; $display("FAIL async_rst_co: q=%h co=%b want 00 0", q60, co60);
        end
        #1 reset = 1'b0;
        m60 = 0; m24 = 0; m1k = 0;
        for (int i = 1; i <= 60; i++) begin
            drive(1, 1, 0, 0, 12'h000);
            checks++;
            if (q60 !== bcd8(i % 60) || co60 !== ((i % 60) == 0)) begin
                errors++; $display("FAIL post_rst step %0d: q=%h co=%b want %h %b",
                                   i, q60, co60, bcd8(i % 60), (i % 60) == 0);
            end
        end
    endtask

    task automatic test_mod24();
        drive(0, 1, 0, 1, 12'h022);
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (q24 !== 8'h23 || co24 !== 1'b0) begin
            errors++; $display("FAIL m24_23: q=%h co=%b want 23 0", q24, co24);
        end
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (q24 !== 8'h00 || co24 !== 1'b1) begin
            errors++; $display("FAIL m24_wrap: q=%h co=%b want 00 1", q24, co24);
        end
        drive(1, 0, 0, 0, 12'h000);
        checks++;
        if (q24 !== 8'h23 || co24 !== 1'b1) begin
            errors++; $display("FAIL m24_down_wrap: q=%h co=%b want 23 1", q24, co24);
        end
        drive(0, 1, 0, 1, 12'h024);
        checks++;
        if (q24 !== 8'h23 || le24 !== 1'b1) begin
            errors++; $display("FAIL m24_bad_load: q=%h err=%b want 23 1", q24, le24);
        end
    endtask

    task automatic test_mod1000();
        drive(0, 1, 0, 1, 12'h098);
        drive(1, 1, 0, 0, 12'h000);
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (q1k !== 12'h100 || co1k !== 1'b0) begin
            errors++; $display("FAIL m1k_carry: q=%h co=%b want 100 0", q1k, co1k);
        end
        drive(0, 1, 0, 1, 12'h998);
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (q1k !== 12'h999 || co1k !== 1'b0) begin
            errors++; $display("FAIL m1k_999: q=%h co=%b want 999 0", q1k, co1k);
        end
        drive(1, 1, 0, 0, 12'h000);
        checks++;
        if (q1k !== 12'h000 || co1k !== 1'b1) begin
            errors++; $display("FAIL m1k_wrap: q=%h co=%b want 000 1", q1k, co1k);
        end
        drive(1, 0, 0, 0, 12'h000);
        checks++;
        if (q1k !== 12'h999 || co1k !== 1'b1) begin
            errors++; $display("FAIL m1k_down_wrap: q=%h co=%b want 999 1", q1k, co1k);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit e, u, c, l;
            logic [11:0] lv;
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            c  = ($urandom_range(0, 15) == 0);
            l  = ($urandom_range(0, 7) == 0);
            lv = 12'($urandom_range(0, 4095));
            drive(e, u, c, l, lv);
            checks++;
            if (q60 !== bcd8(m60) || co60 !== c60 || le60 !== e60) begin
                errors++; $display("FAIL rand60 #%0d: q=%h co=%b err=%b want %h %b %b",
                                   i, q60, co60, le60, bcd8(m60), c60, e60);
            end
            checks++;
            if (q24 !== bcd8(m24) || co24 !== c24 || le24 !== e24) begin
                errors++; $display("FAIL rand24 #%0d: q=%h co=%b err=%b want %h %b %b",
                                   i, q24, co24, le24, bcd8(m24), c24, e24);
            end
            checks++;
            if (q1k !== bcd12(m1k) || co1k !== c1k || le1k !== e1k) begin
                errors++; $display("FAIL rand1k #%0d: q=%h co=%b err=%b want %h %b %b",
                                   i, q1k, co1k, le1k, bcd12(m1k), c1k, e1k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_priority();
        test_async_reset();
        test_mod24();
        test_mod1000();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
